// File: rtl/adder_display_ctrl_if.sv
// rtl/adder_display_ctrl_if.sv - board-side switch, button, LED and 7-segment signal bundle
interface adder_display_ctrl_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             pb;
  logic [WIDTH-1:0] S;
  logic             ovf;
  logic [3:0]       an;
  logic [7:0]       seg;

  // Board side: drives switches and button, observes LEDs and display
  modport master (
    output A, B, pb,
    input  S, ovf, an, seg
  );

  // Datapath side: consumes switches and button, drives LEDs and display
  modport slave (
    input  A, B, pb,
    output S, ovf, an, seg
  );
endinterface

// File: rtl/adder_display_ctrl.sv
// rtl/adder_display_ctrl.sv - registered adder with debounced button and 4-digit hex display scanner
module adder_display_ctrl #(
  parameter int WIDTH           = 7,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_DIV        = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_display_ctrl_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int SC_W = $clog2(SCAN_DIV);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(SCAN_DIV - 1);
  // Legacy lab behaviour flips the two top sum bits while the button is held
  localparam logic [WIDTH-1:0] INV_MASK = WIDTH'(3) << (WIDTH - 2);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             pb_s1_q, pb_s1_d, pb_s2_q, pb_s2_d;
  logic             pb_db_q, pb_db_d, pb_db_prev_q, pb_db_prev_d;
  logic             mode_q, mode_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [SC_W-1:0]  pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [15:0]      disp_val;
  logic [3:0]       nib;
  logic             dp_lit;

  // Active-low {g..a} pattern for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Operand capture, sum, button synchroniser, debouncer and mode toggle
  always_comb begin
    a_d          = bus.A;
    b_d          = bus.B;
    sum_d        = {1'b0, a_q} + {1'b0, b_q};
    pb_s1_d      = bus.pb;
    pb_s2_d      = pb_s1_q;
    pb_db_d      = pb_db_q;
    db_cnt_d     = db_cnt_q;
    pb_db_prev_d = pb_db_q;
    // Count only while the synchronised level disagrees with the debounced one;
    // any return to agreement restarts the stability window
    if (pb_s2_q == pb_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      pb_db_d  = pb_s2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    // Only a press (rising debounced edge) flips the display mode
    mode_d = mode_q ^ (pb_db_q & ~pb_db_prev_q);
  end

  // Digit prescaler and index; content selection for the current digit
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == SC_MAX) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
    disp_val = mode_q ? {8'(a_q), 8'(b_q)} : 16'(sum_q);
    nib      = disp_val[{idx_q, 2'b00} +: 4];
    dp_lit   = mode_q && (idx_q == 2'd2);
    an_d     = ~(4'b0001 << idx_q);
    seg_d    = {~dp_lit, hex7(nib)};
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      pb_s1_q      <= 1'b0;
      pb_s2_q      <= 1'b0;
      pb_db_q      <= 1'b0;
      pb_db_prev_q <= 1'b0;
      mode_q       <= 1'b0;
      db_cnt_q     <= '0;
      pre_q        <= '0;
      idx_q        <= 2'd0;
      an_q         <= 4'hF;
      seg_q        <= 8'hFF;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      pb_s1_q      <= pb_s1_d;
      pb_s2_q      <= pb_s2_d;
      pb_db_q      <= pb_db_d;
      pb_db_prev_q <= pb_db_prev_d;
      mode_q       <= mode_d;
      db_cnt_q     <= db_cnt_d;
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.S   = sum_q[WIDTH-1:0] ^ (pb_db_q ? INV_MASK : '0);
  assign bus.ovf = sum_q[WIDTH];
  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_adder_display_ctrl.sv
// tb/tb_adder_display_ctrl.sv - directed self-checking bench for adder_display_ctrl
module tb_adder_display_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  adder_display_ctrl_if #(.WIDTH(7)) bus ();

  adder_display_ctrl #(
    .WIDTH(7),
    .DEBOUNCE_CYCLES(4),
    .SCAN_DIV(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_an(input logic [3:0] target);
    for (int i = 0; i < 64 && bus.an !== target; i++) step(1);
    check_eq("wait_an", 32'(bus.an), 32'(target));
  endtask

  task automatic check_mode(input logic m);
    wait_an(4'b1011);
    check_eq("mode_dp", 32'(bus.seg[7]), m ? 32'd0 : 32'd1);
  endtask

  task automatic press(input int n);
    bus.pb = 1'b1;
    step(n);
    bus.pb = 1'b0;
    step(10);
  endtask

  task automatic scan_check(input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_seg [4];
    logic [3:0] exp_an;
    int         d;
    exp_seg[0] = e0;
    exp_seg[1] = e1;
    exp_seg[2] = e2;
    exp_seg[3] = e3;
    wait_an(4'b0111);
    wait_an(4'b1110);
    for (int c = 0; c < 32; c++) begin
      d      = c / 8;
      exp_an = ~(4'b0001 << d);
      check_eq("scan_an", 32'(bus.an), 32'(exp_an));
      check_eq("scan_seg", 32'(bus.seg), 32'(exp_seg[d]));
      step(1);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    bus.A  = 7'd5;
    bus.B  = 7'd3;
    bus.pb = 1'b0;
    step(3);
    check_eq("rst_S", 32'(bus.S), 32'd0);
    check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
    check_eq("rst_an", 32'(bus.an), 32'hF);
    check_eq("rst_seg", 32'(bus.seg), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check_eq("first_an", 32'(bus.an), 32'hE);
    step(1);
    check_eq("first_S", 32'(bus.S), 32'd8);
    check_eq("first_ovf", 32'(bus.ovf), 32'd0);

    bus.A = 7'd10; bus.B = 7'd12; step(2);
    check_eq("add_22", 32'(bus.S), 32'd22);
    bus.A = 7'd63; bus.B = 7'd1; step(2);
    check_eq("add_64", 32'(bus.S), 32'd64);
    check_eq("add_64_ovf", 32'(bus.ovf), 32'd0);
    bus.A = 7'd127; bus.B = 7'd1; step(2);
    check_eq("wrap_S", 32'(bus.S), 32'd0);
    check_eq("wrap_ovf", 32'(bus.ovf), 32'd1);

    bus.A = 7'd21; bus.B = 7'd10; bus.pb = 1'b1;
    step(10);
    check_eq("inv_held", 32'(bus.S), 32'h7F);
    bus.pb = 1'b0;
    step(10);
    check_eq("inv_release", 32'(bus.S), 32'h1F);

    rst_n = 1'b0;
    #1;
    check_eq("async_rst_an", 32'(bus.an), 32'hF);
    check_eq("async_rst_S", 32'(bus.S), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check_mode(1'b0);

    for (int w = 1; w <= 3; w++) begin
      bus.pb = 1'b1;
      step(w);
      bus.pb = 1'b0;
      step(8);
      check_eq("glitch_S", 32'(bus.S), 32'h1F);
    end
    check_mode(1'b0);

    bus.pb = 1'b1;
    step(5);
    check_eq("db_not_yet", 32'(bus.S), 32'h1F);
    step(1);
    check_eq("db_rise", 32'(bus.S), 32'h7F);
    bus.pb = 1'b0;
    step(10);
    check_eq("db_fall", 32'(bus.S), 32'h1F);
    check_mode(1'b1);
    press(6);
    check_mode(1'b0);

    bus.A = 7'h3F; bus.B = 7'h01; step(3);
    scan_check(8'hC0, 8'h99, 8'hC0, 8'hC0);

    bus.A = 7'h3A; bus.B = 7'h0B;
    press(6);
    scan_check(8'h83, 8'hC0, 8'h08, 8'hB0);

    step(3);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_an", 32'(bus.an), 32'hF);
    check_eq("mid_rst_seg", 32'(bus.seg), 32'hFF);
    check_eq("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check_mode(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
